// File: rtl/debug_display_if.sv
// Debug-display port bundle: debug mux byte/selector, operator controls and LED digit drive.
interface debug_display_if;
  logic [7:0] din;
  logic       step;
  logic       auto_en;
  logic       freeze;
  logic       blank_en;
  logic [1:0] dsel;
  logic [3:0] sel_led;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (
    output din, step, auto_en, freeze, blank_en,
    input  dsel, sel_led, seg, an
  );

  modport slave (
    input  din, step, auto_en, freeze, blank_en,
    output dsel, sel_led, seg, an
  );
endinterface

// File: rtl/debug_display.sv
// Two-digit hex debug display: steps/auto-cycles a 2-bit mux selector and
// multiplexes the captured byte onto an active-low 7-segment pair.
module debug_display #(
  parameter int unsigned REFRESH_DIV = 16,
  parameter int unsigned AUTO_DIV    = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  debug_display_if.slave bus
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned AW = $clog2(AUTO_DIV);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_DIV - 1);

  logic [2:0]    sync_q,     sync_d;
  logic [1:0]    vld_q,      vld_d;
  logic          arm_q,      arm_d;
  logic [AW-1:0] auto_cnt_q, auto_cnt_d;
  logic [RW-1:0] ref_cnt_q,  ref_cnt_d;
  logic          digit_q,    digit_d;
  logic [1:0]    dsel_q,     dsel_d;
  logic [7:0]    disp_q,     disp_d;

  logic       step_rise;
  logic       auto_pulse;
  logic [3:0] nib;
  logic [6:0] seg_raw;
  logic [6:0] seg_out;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Step edge detect is armed only once the synchroniser has seen step low,
  // so a button held through reset release does not count as a press.
  always_comb begin
    sync_d    = {sync_q[1:0], bus.step};
    vld_d     = {vld_q[0], 1'b1};
    arm_d     = arm_q | (vld_q[1] & ~sync_q[1]);
    step_rise = arm_q & sync_q[1] & ~sync_q[2];
  end

  // Auto-advance divider: cleared while disabled, paused while frozen.
  always_comb begin
    auto_cnt_d = auto_cnt_q;
    auto_pulse = 1'b0;
    if (!bus.auto_en) begin
      auto_cnt_d = '0;
    end else if (!bus.freeze) begin
      if (auto_cnt_q == AUTO_LAST) begin
        auto_cnt_d = '0;
        auto_pulse = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + AW'(1);
      end
    end
  end

  // Coincident step/auto pulses merge into a single advance; frozen pulses are dropped.
  always_comb begin
    dsel_d = dsel_q;
    disp_d = disp_q;
    if (!bus.freeze) begin
      disp_d = bus.din;
      if (step_rise || auto_pulse) begin
        dsel_d = dsel_q + 2'd1;
      end
    end
  end

  // Free-running digit refresh.
  always_comb begin
    ref_cnt_d = ref_cnt_q + RW'(1);
    digit_d   = digit_q;
    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = '0;
      digit_d   = ~digit_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      vld_q      <= '0;
      arm_q      <= 1'b0;
      auto_cnt_q <= '0;
      ref_cnt_q  <= '0;
      digit_q    <= 1'b0;
      dsel_q     <= '0;
      disp_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      vld_q      <= vld_d;
      arm_q      <= arm_d;
      auto_cnt_q <= auto_cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      digit_q    <= digit_d;
      dsel_q     <= dsel_d;
      disp_q     <= disp_d;
    end
  end

  // Digit decode from registered state; blank_en is the only live input here.
  always_comb begin
    nib     = digit_q ? disp_q[7:4] : disp_q[3:0];
    seg_raw = hex_seg(nib);
    seg_out = seg_raw;
    if (digit_q && bus.blank_en && (nib == 4'h0)) begin
      seg_out = 7'h7F;
    end
  end

  assign bus.dsel    = dsel_q;
  assign bus.sel_led = 4'(4'b0001 << dsel_q);
  assign bus.seg     = seg_out;
  assign bus.an      = digit_q ? 2'b01 : 2'b10;

endmodule

// File: tb/tb_debug_display.sv
// Directed bench for debug_display: decode table plus reset, step, auto, freeze sequences.
module tb_debug_display;

  logic clk;
  logic rst_n;
  int unsigned cyc;
  int errors;
  int checks;
  logic [1:0] exp_dsel;

  debug_display_if bus();

  debug_display #(.REFRESH_DIV(16), .AUTO_DIV(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] din;
    logic       blank;
    logic [6:0] lo;
    logic [6:0] hi;
  } vec_t;

  vec_t vecs[12];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference clock count since reset release; digit model = bit 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic chk_dsel(input string name);
    chk({name, ".dsel"}, 8'(bus.dsel), 8'(exp_dsel));
    chk({name, ".sel_led"}, 8'(bus.sel_led), 8'(4'b0001 << exp_dsel));
  endtask

  task automatic check_disp(input string name, input logic [7:0] b, input logic blank);
    logic       d;
    logic [3:0] n;
    logic [6:0] es;
    logic [1:0] ea;
    d  = cyc[4];
    n  = d ? b[7:4] : b[3:0];
    es = (d && blank && n == 4'h0) ? 7'h7F : hex7(n);
    ea = d ? 2'b01 : 2'b10;
    chk({name, ".seg"}, 8'(bus.seg), 8'(es));
    chk({name, ".an"}, 8'(bus.an), 8'(ea));
  endtask

  // Press: sampled at edge N, dsel must move at N+2 and not before.
  task automatic step_press(input string name);
    bus.step = 1'b1;
    tick();
    chk_dsel({name, ".n0"});
    tick();
    chk_dsel({name, ".n1"});
    tick();
    exp_dsel = exp_dsel + 2'd1;
    chk_dsel({name, ".n2"});
    bus.step = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    exp_dsel = 2'd0;
    vecs[0]  = '{8'h0A, 1'b1, 7'h08, 7'h7F};
    vecs[1]  = '{8'h05, 1'b0, 7'h12, 7'h40};
    vecs[2]  = '{8'h05, 1'b1, 7'h12, 7'h7F};
    vecs[3]  = '{8'h3C, 1'b0, 7'h46, 7'h30};
    vecs[4]  = '{8'hA7, 1'b1, 7'h78, 7'h08};
    vecs[5]  = '{8'hF1, 1'b0, 7'h79, 7'h0E};
    vecs[6]  = '{8'h00, 1'b1, 7'h40, 7'h7F};
    vecs[7]  = '{8'h00, 1'b0, 7'h40, 7'h40};
    vecs[8]  = '{8'h96, 1'b0, 7'h02, 7'h10};
    vecs[9]  = '{8'hE2, 1'b1, 7'h24, 7'h06};
    vecs[10] = '{8'hD8, 1'b0, 7'h00, 7'h21};
    vecs[11] = '{8'h4B, 1'b1, 7'h03, 7'h19};

    rst_n        = 1'b1;
    bus.din      = 8'h0A;
    bus.step     = 1'b1;
    bus.auto_en  = 1'b0;
    bus.freeze   = 1'b0;
    bus.blank_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.dsel", 8'(bus.dsel), 8'h00);
    chk("rst.sel_led", 8'(bus.sel_led), 8'h01);
    chk("rst.an", 8'(bus.an), 8'h02);
    chk("rst.seg", 8'(bus.seg), 8'h40);
    tick();
    tick();
    chk("rst_hold.seg", 8'(bus.seg), 8'h40);

    // Release with step held high; first refresh toggle at edge 16.
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 1)  begin chk("rel1.seg", 8'(bus.seg), 8'h08); chk("rel1.an", 8'(bus.an), 8'h02); end
      if (k == 15) begin chk("rel15.seg", 8'(bus.seg), 8'h08); chk("rel15.an", 8'(bus.an), 8'h02); end
      if (k == 16) begin chk("rel16.seg", 8'(bus.seg), 8'h7F); chk("rel16.an", 8'(bus.an), 8'h01); end
      if (k == 32) begin chk("rel32.seg", 8'(bus.seg), 8'h08); chk("rel32.an", 8'(bus.an), 8'h02); end
    end
    chk_dsel("held_step");

    bus.step = 1'b0;
    repeat (4) tick();
    chk_dsel("after_release");
    step_press("step1");
    step_press("step2");
    step_press("step3");
    step_press("step4");

    // Decode table, both digits per vector.
    for (int i = 0; i < 12; i++) begin
      bus.din      = vecs[i].din;
      bus.blank_en = vecs[i].blank;
      tick();
      while (cyc[4] != 1'b0) tick();
      chk($sformatf("vec%0d.lo", i), 8'(bus.seg), 8'(vecs[i].lo));
      chk($sformatf("vec%0d.an0", i), 8'(bus.an), 8'h02);
      while (cyc[4] != 1'b1) tick();
      chk($sformatf("vec%0d.hi", i), 8'(bus.seg), 8'(vecs[i].hi));
      chk($sformatf("vec%0d.an1", i), 8'(bus.an), 8'h01);
    end

    // Freeze holds byte and selector; a frozen press is lost.
    bus.blank_en = 1'b0;
    bus.din      = 8'h3C;
    tick();
    tick();
    bus.freeze = 1'b1;
    bus.din    = 8'h5A;
    repeat (3) tick();
    check_disp("frz_a", 8'h3C, 1'b0);
    bus.step = 1'b1;
    repeat (3) tick();
    chk_dsel("frz_step");
    bus.step = 1'b0;
    repeat (3) tick();
    begin
      logic d0;
      d0 = cyc[4];
      while (cyc[4] == d0) tick();
    end
    check_disp("frz_b", 8'h3C, 1'b0);
    bus.freeze = 1'b0;
    tick();
    check_disp("unfrz", 8'h5A, 1'b0);
    repeat (3) tick();
    chk_dsel("unfrz");

    // Auto-advance every 64 clocks; coincident press counts once.
    bus.auto_en = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 63)  chk_dsel("auto63");
      if (k == 64)  begin exp_dsel = exp_dsel + 2'd1; chk_dsel("auto64"); end
      if (k == 127) chk_dsel("auto127");
      if (k == 128) begin exp_dsel = exp_dsel + 2'd1; chk_dsel("auto128"); end
      if (k == 189) bus.step = 1'b1;
      if (k == 191) chk_dsel("coin191");
      if (k == 192) begin exp_dsel = exp_dsel + 2'd1; chk_dsel("coin192"); end
      if (k == 193) bus.step = 1'b0;
      if (k == 200) chk_dsel("coin200");
    end
    bus.auto_en = 1'b0;
    repeat (70) tick();
    chk_dsel("auto_off");
    bus.freeze  = 1'b1;
    bus.auto_en = 1'b1;
    repeat (70) tick();
    chk_dsel("auto_frozen");
    bus.auto_en = 1'b0;
    bus.freeze  = 1'b0;
    tick();

    // Reset mid-refresh with dsel=10.
    while (exp_dsel != 2'd2) step_press("to2");
    chk_dsel("pre_rst");
    while (cyc % 16 != 7) tick();
    bus.din = 8'h05;
    rst_n   = 1'b0;
    #1;
    exp_dsel = 2'd0;
    chk_dsel("mid_rst");
    chk("mid_rst.an", 8'(bus.an), 8'h02);
    chk("mid_rst.seg", 8'(bus.seg), 8'h40);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1)  chk("mrel1.seg", 8'(bus.seg), 8'h12);
      if (k == 15) chk("mrel15.an", 8'(bus.an), 8'h02);
      if (k == 16) begin chk("mrel16.an", 8'(bus.an), 8'h01); chk("mrel16.seg", 8'(bus.seg), 8'h40); end
    end
    chk_dsel("mrel");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
